// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 device-to-host frame receiver. Delivers validated scan codes
//            with break/extended qualifiers; F0/E0 prefixes are absorbed.
// Revision : 1.0
// ============================================================================
module ps2_frame_rx #(
    parameter int FILTER_LEN = 20,
    parameter int TIMEOUT    = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    output logic       is_break_o,
    output logic       is_ext_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int              c_FW   = $clog2(FILTER_LEN + 1);
    localparam int              c_TW   = $clog2(TIMEOUT + 1);
    localparam logic [c_FW-1:0] c_FLEN = c_FW'(FILTER_LEN);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Bit 0 carries kclk, bit 1 carries kdata.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      sync3_q;
    logic [c_FW-1:0] fcnt_q [2];
    logic [1:0]      filt_q;
    logic [1:0]      filt_d;
    logic            fall_q;

    state_t          state_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            brk_pend_q;
    logic            ext_pend_q;
    logic [c_TW-1:0] tcnt_q;
    logic [7:0]      code_q;
    logic            valid_q;
    logic            brk_q;
    logic            ext_q;
    logic            err_q;
    logic            busy_q;

    // A line is only accepted once it has been stable for the full window;
    // comparing against the previous synchronized sample keeps a change
    // from passing through while the counter is still saturated.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            if ((fcnt_q[i] == c_FLEN) && (sync2_q[i] == sync3_q[i])) begin
                filt_d[i] = sync2_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            sync3_q   <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            filt_q    <= 2'b11;
            fall_q    <= 1'b0;
        end else begin
            sync1_q <= {kdata_i, kclk_i};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != sync3_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] != c_FLEN) begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
            filt_q <= filt_d;
            fall_q <= filt_q[0] & ~filt_d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            tcnt_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if ((state_q == S_IDLE) || fall_q) begin
                tcnt_q <= '0;
            end else if (tcnt_q != c_TMAX) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            // A fall in the same cycle as the threshold takes priority.
            if ((state_q != S_IDLE) && !fall_q && (tcnt_q == c_TMAX)) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                brk_pend_q <= 1'b0;
                ext_pend_q <= 1'b0;
            end else if (fall_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (!filt_q[1]) begin
                            state_q  <= S_DATA;
                            bitcnt_q <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shift_q  <= {filt_q[1], shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_q   <= filt_q[1];
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (filt_q[1] && (^{shift_q, par_q})) begin
                            if (shift_q == 8'hF0) begin
                                brk_pend_q <= 1'b1;
                            end else if (shift_q == 8'hE0) begin
                                ext_pend_q <= 1'b1;
                            end else begin
                                code_q     <= shift_q;
                                brk_q      <= brk_pend_q;
                                ext_q      <= ext_pend_q;
                                valid_q    <= 1'b1;
                                brk_pend_q <= 1'b0;
                                ext_pend_q <= 1'b0;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            brk_pend_q <= 1'b0;
                            ext_pend_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign is_break_o   = brk_q;
    assign is_ext_o     = ext_q;
    assign frame_err_o  = err_q;
    assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_frame_rx
// Brief    : Self-checking bench for ps2_frame_rx: frame table plus corner cases.
// Revision : 1.0
// ============================================================================
module tb_ps2_frame_rx;

    localparam int FL = 20;
    localparam int TO = 20000;
    localparam int H  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       kclk_i;
    logic       kdata_i;
    logic [7:0] code_o;
    logic       code_valid_o;
    logic       is_break_o;
    logic       is_ext_o;
    logic       frame_err_o;
    logic       busy_o;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .kclk_i       (kclk_i),
        .kdata_i      (kdata_i),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .is_break_o   (is_break_o),
        .is_ext_o     (is_ext_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_busy  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid_o) n_valid++;
            if (frame_err_o)  n_err++;
            if (busy_o)       n_busy++;
        end
    end

    typedef struct {
        logic [7:0] b;
        logic       pflip;
        logic       stop;
        int         dv;
        int         de;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic d);
        kdata_i = d;
        wait_cyc(H);
        kclk_i = 1'b0;
        wait_cyc(H);
        kclk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ pflip);
        ps2_bit(stop);
        kdata_i = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"},  {24'd0, code_o}, 32'h00);
        chk({tag, "_valid"}, {31'd0, code_valid_o}, 32'd0);
        chk({tag, "_brk"},   {31'd0, is_break_o}, 32'd0);
        chk({tag, "_ext"},   {31'd0, is_ext_o}, 32'd0);
        chk({tag, "_err"},   {31'd0, frame_err_o}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int v0, e0, b0;

        tbl[0]  = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D, 1'b0, 1'b0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1D, 1'b0, 1'b0};
        tbl[2]  = '{8'h5A, 1'b0, 1'b1, 1, 0, 8'h5A, 1'b1, 1'b0};
        tbl[3]  = '{8'h5A, 1'b0, 1'b1, 1, 0, 8'h5A, 1'b0, 1'b0};
        tbl[4]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h5A, 1'b0, 1'b0};
        tbl[5]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h5A, 1'b0, 1'b0};
        tbl[6]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
        tbl[7]  = '{8'h29, 1'b1, 1'b1, 0, 1, 8'h75, 1'b1, 1'b1};
        tbl[8]  = '{8'h29, 1'b0, 1'b0, 0, 1, 8'h75, 1'b1, 1'b1};
        tbl[9]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b1};
        tbl[10] = '{8'h29, 1'b1, 1'b1, 0, 1, 8'h75, 1'b1, 1'b1};
        tbl[11] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        tbl[12] = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        tbl[13] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b1};

        rst     = 1'b1;
        kclk_i  = 1'b1;
        kdata_i = 1'b1;
        wait_cyc(5);
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        wait_cyc(FL + 10);
        chk_reset_vals("rst_rel");

        for (int k = 0; k < 14; k++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(tbl[k].b, tbl[k].pflip, tbl[k].stop);
            chk($sformatf("v%0d_nvalid", k), n_valid - v0, tbl[k].dv);
            chk($sformatf("v%0d_nerr", k),   n_err - e0,   tbl[k].de);
            chk($sformatf("v%0d_code", k),   {24'd0, code_o}, {24'd0, tbl[k].code});
            chk($sformatf("v%0d_brk", k),    {31'd0, is_break_o}, {31'd0, tbl[k].brk});
            chk($sformatf("v%0d_ext", k),    {31'd0, is_ext_o}, {31'd0, tbl[k].ext});
        end

        // Truncated frame: start plus four data bits, then silence.
        v0 = n_valid;
        e0 = n_err;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        chk("to_busy_mid", {31'd0, busy_o}, 32'd1);
        wait_cyc(TO + 10);
        chk("to_nerr",   n_err - e0, 1);
        chk("to_nvalid", n_valid - v0, 0);
        chk("to_busy",   {31'd0, busy_o}, 32'd0);
        send_frame(8'h43, 1'b0, 1'b1);
        chk("to_next_nvalid", n_valid - v0, 1);
        chk("to_next_code",   {24'd0, code_o}, 32'h43);
        chk("to_next_brk",    {31'd0, is_break_o}, 32'd0);

        // Short kclk glitches while idle must be filtered out.
        v0 = n_valid;
        e0 = n_err;
        b0 = n_busy;
        for (int g = 0; g < 4; g++) begin
            kclk_i = 1'b0;
            wait_cyc(5);
            kclk_i = 1'b1;
            wait_cyc(30);
        end
        chk("gl_nvalid", n_valid - v0, 0);
        chk("gl_nerr",   n_err - e0, 0);
        chk("gl_nbusy",  n_busy - b0, 0);

        // Reset mid-frame with a break prefix pending.
        send_frame(8'hF0, 1'b0, 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        chk("mr_busy_mid", {31'd0, busy_o}, 32'd1);
        v0 = n_valid;
        e0 = n_err;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(FL + 10);
        chk_reset_vals("mr");
        send_frame(8'h1D, 1'b0, 1'b1);
        chk("mr_next_nvalid", n_valid - v0, 1);
        chk("mr_next_nerr",   n_err - e0, 0);
        chk("mr_next_code",   {24'd0, code_o}, 32'h1D);
        chk("mr_next_brk",    {31'd0, is_break_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
